// File: rtl/lopd_norm_pipe.sv
// Pipelined leading-one position detector and left normaliser for the adder
// mantissa path. Stage 1 counts leading zeros, stage 2 shifts the magnitude.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_flush                 drop all in-flight items at the next edge
//   i_valid/o_ready         input handshake (o_ready is combinational)
//   i_data, i_tag           magnitude to normalise and its sideband tag
//   o_valid/i_ready         output handshake
//   o_lzc, o_zero, o_mant   leading-zero count, zero flag, normalised magnitude
//   o_tag                   tag returned with the result
module lopd_norm_pipe #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned TAG_W = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIDTH-1:0]           i_data,
  input  logic [TAG_W-1:0]           i_tag,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(WIDTH)-1:0]   o_lzc,
  output logic                       o_zero,
  output logic [WIDTH-1:0]           o_mant,
  output logic [TAG_W-1:0]           o_tag
);

  localparam int unsigned LZW = $clog2(WIDTH);
  localparam int unsigned PW  = 1 << LZW;

  logic             en1, en2;
  logic             v1, v2;
  logic [WIDTH-1:0] d1, m2;
  logic [LZW-1:0]   lzc1, lzc2;
  logic             z1, z2;
  logic [TAG_W-1:0] tag1, tag2;

  logic [PW-1:0]    win;
  logic             upper_zero;
  logic [LZW-1:0]   lzc_tree;
  logic             zero_in;
  logic [LZW-1:0]   lzc_in;

  // Stage enables: a stage may load when it is empty or its successor moves.
  always_comb begin
    en2     = !v2 || i_ready;
    en1     = !v1 || en2;
    o_ready = en1 && !i_flush;
  end

  // Halving LOPD tree on the LSB-padded word: each level tests the upper half of
  // the current window; that flag is the next lzc bit and picks the half to keep.
  always_comb begin
    win        = PW'(i_data) << (PW - WIDTH);
    lzc_tree   = '0;
    upper_zero = 1'b0;
    for (int lvl = int'(LZW) - 1; lvl >= 0; lvl--) begin
      upper_zero = ((win >> (PW - (1 << lvl))) == '0);
      lzc_tree   = LZW'({lzc_tree, upper_zero});
      if (upper_zero) begin
        win = win << (1 << lvl);
      end
    end
    zero_in = (i_data == '0);
    // An all-zero word would walk into the padding; clamp to the last real bit.
    lzc_in  = zero_in ? LZW'(WIDTH - 1) : lzc_tree;
  end

  // Valid flops; flush wins over every handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (i_flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (en1) v1 <= i_valid;
      if (en2) v2 <= v1;
    end
  end

  // Stage 1 detect registers: load only on an accepted item.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      d1   <= '0;
      lzc1 <= '0;
      z1   <= 1'b0;
      tag1 <= '0;
    end else if (en1 && i_valid && !i_flush) begin
      d1   <= i_data;
      lzc1 <= lzc_in;
      z1   <= zero_in;
      tag1 <= i_tag;
    end
  end

  // Stage 2 normalise registers: held while the result is stalled downstream.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m2   <= '0;
      lzc2 <= '0;
      z2   <= 1'b0;
      tag2 <= '0;
    end else if (en2 && v1 && !i_flush) begin
      m2   <= d1 << lzc1;
      lzc2 <= lzc1;
      z2   <= z1;
      tag2 <= tag1;
    end
  end

  always_comb begin
    o_valid = v2;
    o_lzc   = lzc2;
    o_zero  = z2;
    o_mant  = m2;
    o_tag   = tag2;
  end

endmodule

// File: tb/tb_lopd_norm_pipe.sv
module tb_lopd_norm_pipe;

  localparam int unsigned W  = 24;
  localparam int unsigned TW = 4;
  localparam int unsigned LW = 5;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  in_data;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          in_ready;
  logic [LW-1:0] out_lzc;
  logic          out_zero;
  logic [W-1:0]  out_mant;
  logic [TW-1:0] out_tag;

  logic          flush5, valid5, ready5, o_ready5, o_valid5, o_zero5;
  logic [4:0]    data5, o_mant5;
  logic [3:0]    tag5, o_tag5;
  logic [2:0]    o_lzc5;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
  } item_t;
  item_t sq[$];

  lopd_norm_pipe #(.WIDTH(W), .TAG_W(TW)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(in_valid), .o_ready(out_ready),
    .i_data(in_data), .i_tag(in_tag), .o_valid(out_valid), .i_ready(in_ready),
    .o_lzc(out_lzc), .o_zero(out_zero), .o_mant(out_mant), .o_tag(out_tag)
  );

  lopd_norm_pipe #(.WIDTH(5), .TAG_W(4)) u_dut5 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush5), .i_valid(valid5), .o_ready(o_ready5),
    .i_data(data5), .i_tag(tag5), .o_valid(o_valid5), .i_ready(ready5),
    .o_lzc(o_lzc5), .o_zero(o_zero5), .o_mant(o_mant5), .o_tag(o_tag5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: scan from the top real bit for the first one.
  function automatic void ref_norm(input logic [63:0] d, input int w,
                                   output int lzc, output bit zero, output logic [63:0] mant);
    zero = 1'b1;
    lzc  = w - 1;
    for (int b = w - 1; b >= 0; b--) begin
      if (((d >> b) & 64'd1) != 64'd0) begin
        zero = 1'b0;
        lzc  = w - 1 - b;
        break;
      end
    end
    mant = zero ? 64'd0 : ((d << lzc) & ((64'd1 << w) - 64'd1));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [W-1:0] d, input logic [TW-1:0] t);
    in_valid = v;
    in_data  = d;
    in_tag   = t;
  endtask

  // Scoreboard and compare process, sampled mid-cycle when everything is settled.
  logic [63:0] prev_out;
  logic        hold = 1'b0;
  always @(negedge clk) begin
    int          lzc;
    bit          zero;
    logic [63:0] mant;
    logic [63:0] cur;
    cur = 64'({out_valid, out_lzc, out_zero, out_mant, out_tag});
    if (rst) begin
      sq.delete();
      hold = 1'b0;
    end else begin
      if (hold) chk("stall_stable", cur, prev_out);
      if (out_valid) begin
        if (sq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual_tag=%h required=none at %0t", out_tag, $time);
        end else begin
          ref_norm(64'(sq[0].d), W, lzc, zero, mant);
          chk("model_out", 64'({out_lzc, out_zero, out_mant, out_tag}),
              64'({LW'(lzc), zero, W'(mant), sq[0].t}));
        end
      end
      hold     = out_valid && !in_ready && !flush;
      prev_out = cur;
      if (flush) begin
        sq.delete();
      end else begin
        if (out_valid && in_ready && sq.size() > 0) begin
          void'(sq.pop_front());
          n_out++;
        end
        if (in_valid && out_ready) sq.push_back('{d: in_data, t: in_tag});
      end
    end
  end

  logic [W-1:0] data4 [4];
  initial begin
    int idx, acc, base, lzc;
    bit acc_now, zero;
    logic [63:0] mant;

    data4[0] = 24'h000100; data4[1] = 24'h0F0000;
    data4[2] = 24'h000003; data4[3] = 24'hFFFFFF;
    rst = 1'b1; flush = 1'b0; in_ready = 1'b0; offer(1'b0, '0, '0);
    flush5 = 1'b0; valid5 = 1'b0; ready5 = 1'b1; data5 = '0; tag5 = '0;
    repeat (2) step();
    chk("reset_outs", 64'({out_valid, out_lzc, out_zero, out_mant, out_tag}), 64'd0);
    chk("reset_ready", 64'(out_ready), 64'd1);
    rst = 1'b0;
    step();

    // Single item latency and minimum-magnitude input.
    in_ready = 1'b1;
    offer(1'b1, 24'h000001, 4'h1);
    #1 chk("t1_ready", 64'(out_ready), 64'd1);
    step(); offer(1'b0, '0, '0);
    chk("t1_not_yet", 64'(out_valid), 64'd0);
    step();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_out", 64'({out_lzc, out_zero, out_mant, out_tag}), 64'({5'd23, 1'b0, 24'h800000, 4'h1}));
    step();

    // MSB-set and zero inputs back to back.
    offer(1'b1, 24'h800000, 4'h2); step();
    offer(1'b1, 24'h000000, 4'h3); step();
    chk("t2_msb", 64'({out_valid, out_lzc, out_zero, out_mant, out_tag}), 64'({1'b1, 5'd0, 1'b0, 24'h800000, 4'h2}));
    offer(1'b0, '0, '0); step();
    chk("t2_zero", 64'({out_valid, out_lzc, out_zero, out_mant, out_tag}), 64'({1'b1, 5'd23, 1'b1, 24'h000000, 4'h3}));
    step();

    // Full throughput burst.
    offer(1'b1, 24'h00F000, 4'h4); step();
    offer(1'b1, 24'h0000FF, 4'h5); step();
    offer(1'b1, 24'h400000, 4'h6);
    chk("t3_a", 64'({out_valid, out_lzc, out_tag}), 64'({1'b1, 5'd8, 4'h4}));
    step(); offer(1'b0, '0, '0);
    chk("t3_b", 64'({out_valid, out_lzc, out_tag}), 64'({1'b1, 5'd16, 4'h5}));
    step();
    chk("t3_c", 64'({out_valid, out_lzc, out_tag}), 64'({1'b1, 5'd1, 4'h6}));
    step();
    chk("t3_empty", 64'(out_valid), 64'd0);

    // Backpressure: only two items fit.
    in_ready = 1'b0; idx = 0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      offer(idx < 4, (idx < 4) ? data4[idx] : '0, TW'(7 + idx));
      #1 acc_now = out_ready && in_valid;
      step();
      if (acc_now) begin idx++; acc++; end
    end
    #1 chk("t4_accepted", 64'(acc), 64'd2);
    chk("t4_ready_low", 64'(out_ready), 64'd0);
    chk("t4_head", 64'({out_valid, out_lzc, out_tag}), 64'({1'b1, 5'd15, 4'h7}));
    in_ready = 1'b1; base = n_out;
    for (int c = 0; c < 20 && (n_out - base) < 4; c++) begin
      offer(idx < 4, (idx < 4) ? data4[idx] : '0, TW'(7 + idx));
      #1 acc_now = out_ready && in_valid;
      step();
      if (acc_now) idx++;
    end
    offer(1'b0, '0, '0);
    chk("t4_all_out", 64'(n_out - base), 64'd4);

    // Flush with a full pipe and an item on offer.
    step();
    in_ready = 1'b0;
    offer(1'b1, 24'h001234, 4'hB); step();
    offer(1'b1, 24'h020000, 4'hC); step();
    chk("t5_full", 64'(out_valid), 64'd1);
    flush = 1'b1; offer(1'b1, 24'h000777, 4'hD);
    #1 chk("t5_ready_low", 64'(out_ready), 64'd0);
    step();
    flush = 1'b0; offer(1'b0, '0, '0);
    chk("t5_valid_low", 64'(out_valid), 64'd0);
    in_ready = 1'b1; base = n_out;
    repeat (4) step();
    chk("t5_none_out", 64'(n_out - base), 64'd0);

    // Async reset with a full pipe.
    in_ready = 1'b0;
    offer(1'b1, 24'h000010, 4'hE); step();
    offer(1'b1, 24'h000020, 4'hF); step();
    offer(1'b0, '0, '0);
    chk("t6_full", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1 chk("t6_rst_now", 64'(out_valid), 64'd0);
    step();
    rst = 1'b0;
    #1 chk("t6_ready", 64'({out_ready, out_valid}), 64'({1'b1, 1'b0}));
    step();

    // Random traffic with random stalls.
    for (int c = 0; c < 120; c++) begin
      in_ready = 1'($urandom_range(0, 3) != 0);
      offer(1'($urandom_range(0, 1)), W'(W'($urandom) >> $urandom_range(0, 24)), TW'($urandom));
      step();
    end
    offer(1'b0, '0, '0); in_ready = 1'b1;
    for (int c = 0; c < 10 && sq.size() > 0; c++) step();
    chk("drain_empty", 64'(sq.size()), 64'd0);

    // WIDTH=5 exhaustive sweep.
    for (int j = 0; j < 34; j++) begin
      valid5 = (j < 32);
      data5  = 5'(j);
      tag5   = 4'(j);
      step();
      if (j >= 1 && j <= 32) begin
        ref_norm(64'(j - 1), 5, lzc, zero, mant);
        chk("w5_sweep", 64'({o_valid5, o_ready5, o_lzc5, o_zero5, o_mant5, o_tag5}),
            64'({1'b1, 1'b1, 3'(lzc), zero, 5'(mant), 4'(j - 1)}));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
